// File: rtl/f_fetch_buf_if.sv
// Fetch buffer bundle: redirect, instruction-memory request/response
// and decode-side queue head, seen from the buffer (master) or its peers.
interface f_fetch_buf_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;
    logic        out_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr, out_adel
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr, out_adel
    );
endinterface

// File: rtl/f_fetch_buf.sv
// Fetch-PC generator with in-order prefetch queue and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise an ADEL entry.
module f_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    f_fetch_buf_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, ERR, HALT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [31:0] r_q_pc    [DEPTH];
    logic [31:0] r_q_instr [DEPTH];

    logic [CW-1:0] w_credit;
    logic [31:0] w_redir_pc;
    logic        w_misal;
    logic        w_req_valid;
    logic        w_out_valid;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_instr;
    logic        w_out_adel;
    logic        w_pop;
    logic        w_issue;
    logic        w_resp;
    logic        w_push;

`ifdef FETCH_ALIGN_CHECK_EN
    logic [31:0] r_err_pc;
    assign w_redir_pc = bus.redirect_pc;
    assign w_misal    = |bus.redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset)
            r_err_pc <= RESET_PC;
        else if (bus.redirect_valid)
            r_err_pc <= bus.redirect_pc;
    end
`else
    logic w_unused;
    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_misal    = 1'b0;
    assign w_unused   = &{1'b0, bus.redirect_pc[1:0]};
`endif

    // Outstanding requests hold queue slots, so pushes never overflow.
    assign w_credit = CW'(DEPTH) - r_count - r_inflight;
    assign w_issue  = w_req_valid && bus.imem_req_ready;
    assign w_resp   = bus.imem_resp_valid && (r_inflight != '0);
    assign w_push   = w_resp && (r_drop == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_out_valid = 1'b0;
        w_out_pc    = r_q_pc[r_head];
        w_out_instr = r_q_instr[r_head];
        w_out_adel  = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            RUN: begin
                w_req_valid = !reset && (w_credit != '0)
                            && !bus.redirect_valid;
                w_out_valid = (r_count != '0);
                w_pop       = w_out_valid && bus.out_ready;
            end
            ERR: begin
`ifdef FETCH_ALIGN_CHECK_EN
                w_out_valid = 1'b1;
                w_out_adel  = 1'b1;
                w_out_pc    = r_err_pc;
                w_out_instr = 32'h0;
                if (bus.out_ready)
                    w_state_nxt = HALT;
`endif
            end
            HALT: begin
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (bus.redirect_valid)
            w_state_nxt = w_misal ? ERR : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_resp);
            if (bus.redirect_valid) begin
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_drop     <= r_inflight + CW'(w_issue) - CW'(w_resp);
            end else begin
                if (w_issue)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp && (r_drop != '0))
                    r_drop <= r_drop - 1'b1;
                if (w_push) begin
                    r_tail    <= r_tail + 1'b1;
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop)
                    r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.redirect_valid && w_push) begin
            r_q_pc[r_tail]    <= r_resp_pc;
            r_q_instr[r_tail] <= bus.imem_resp_data;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_pc         = w_out_pc;
    assign bus.out_instr      = w_out_instr;
    assign bus.out_adel       = w_out_adel;
endmodule

// File: doc/f_fetch_buf.md
Name: f_fetch_buf

Overview:
Parametrised successor to the fetch-stage PC register: fetch-PC generator plus in-order instruction prefetch queue.
- Issues sequential word requests to instruction memory over a valid/ready handshake.
- Accepts in-order responses with variable latency, and buffers {pc, instr} pairs for decode.
- A redirect (branch/jump/exception) flushes the queue and discards in-flight responses.
- Sits between the F-stage next-PC logic and the F/D pipeline register.

Parameters:
RESET_PC, 32'h00003000, fetch PC loaded on reset
DEPTH, 4, queue entries and maximum outstanding requests (power of two, ≥2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
redirect_valid  input  1  load new fetch PC and flush this cycle
redirect_pc  input  32  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch byte address
imem_req_ready  input  1  memory accepts request
imem_resp_valid  input  1  response valid (in order, at most one per cycle)
imem_resp_data  input  32  instruction word
out_valid  output  1  queue head valid
out_pc  output  32  PC of head instruction
out_instr  output  32  head instruction
out_adel  output  1  head is an instruction-address-error entry
out_ready  input  1  decode consumes head

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - count=0, inflight=0, drop_cnt=0, state=RUN.
  - out_valid=0, out_adel=0, imem_req_valid=0.
- Counters are $clog2(DEPTH+1) bits wide. credit = DEPTH - count - inflight, never negative.
- Request issue:
  - imem_req_valid = (state==RUN) && credit>0 && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On valid&ready: fetch_pc += 4 (32-bit wrap) and inflight++.
- Response handling:
  - Each imem_resp_valid decrements inflight.
  - If drop_cnt>0: data is discarded and drop_cnt--.
  - Otherwise push {resp_pc, imem_resp_data} and resp_pc += 4.
  - A response arriving with inflight==0 is ignored.
- Output:
  - out_valid = count>0 (RUN state); head drives out_pc/out_instr.
  - Pop on out_valid&out_ready.
  - Push and pop in the same cycle: count unchanged.
  - No push when full; the credit rule guarantees this.
  - Pop-to-use latency is 0. Request-to-out_valid latency is memory latency + 1 cycle.
- Redirect (highest priority, overrides pop/push of that cycle):
  - Next cycle: count=0, fetch_pc=resp_pc=redirect_pc.
  - drop_cnt = inflight + issued_this_cycle - resp_this_cycle.
  - No request in the redirect cycle.
  - Back-to-back redirects: the latest wins; drop_cnt accumulates correctly.
- Reset mid-operation: all state cleared. The memory is reset in the same cycle.
- States:
  - RUN: normal operation.
  - ERR: feature only.
  - HALT: feature only.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc[1:0]≠0 enters ERR. No requests are issued; drops still proceed.
  - ERR presents out_valid=1, out_adel=1, out_pc=redirect_pc, out_instr=0.
  - A pop in ERR moves to HALT (out_valid=0).
  - Any aligned redirect returns to RUN; a misaligned redirect re-enters ERR.
- Undefined:
  - redirect_pc[1:0] is forced to 00.
  - out_adel is tied 0; ERR and HALT are unreachable.

Test Plan:
- Reset, imem always ready, 1-cycle latency, out_ready=1 → out_pc sequence 0x3000, 0x3004, 0x3008…; out_instr matches memory; out_adel=0.
- out_ready=0, DEPTH=4 → exactly 4 requests issued (0x3000–0x300C), then imem_req_valid=0. Single pop → one new request for 0x3010.
- 3-cycle latency, redirect to 0x4000 with 2 in flight → both stale responses dropped; next out_pc=0x4000; count=0 the cycle after redirect.
- Redirect in the same cycle as an accepted request and a response → drop_cnt correct; no stale instruction ever reaches out_valid.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x4002 → out_valid=1, out_adel=1, out_pc=0x4002, no requests. Pop → out_valid=0. Redirect 0x5000 → fetch resumes at 0x5000.
- Assert reset while queue is full and 2 responses are in flight → next cycle out_valid=0, imem_req_addr=0x3000, counters 0.
